ghostbus_host_arb: RTL

- Two-requester arbiter and sequencer for the single ghostbus host port (address / write data / write-strobe / read-strobe / read data).
- Lets two host engines share one decoded bus tree, e.g. a UART bridge on requester 0 and a JTAG or soft-CPU bridge on requester 1.
- Serialises transactions, generates the one-cycle write/read strobes, waits the fixed read latency, and returns read data with a one-cycle ack.
- Sits at the top of the bus tree, above every auto-decoded module.

---
 rtl/ghostbus_host_arb_pkg.sv | 23 ++
 rtl/ghostbus_host_arb_if.sv | 31 +++
 rtl/ghostbus_arb_grant.sv | 34 +++
 rtl/ghostbus_host_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ghostbus_host_arb_pkg.sv
// ghostbus_host_arb_pkg: shared state encoding and read-latency counter sizing for the host arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ghostbus_host_arb_pkg;

   // Sequencer states; encoding is fixed so debug probes read the same values everywhere.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   // Width of the read-latency down-counter; holds RD_LAT-1 for RD_LAT up to 15.
   localparam int CNT_W = 4;

   // Value loaded into the counter on the read-strobe cycle so that gb_din is
   // sampled exactly rd_lat cycles after gb_re.
   function automatic logic [CNT_W-1:0] lat_load(input int rd_lat);
      return CNT_W'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/ghostbus_host_arb_if.sv
// ghostbus_host_arb_if: host-side ghostbus port (address, write data, strobes, read data).
// Latency: n/a (wires only); strobes are single-cycle, read data returns a fixed latency later.
// Backpressure: none on the bus itself; the arbiter serialises all traffic.
interface ghostbus_host_arb_if #(
   parameter int AW = 24,
   parameter int DW = 32
);
   logic [AW-1:0] gb_addr;
   logic [DW-1:0] gb_dout;
   logic          gb_we;
   logic          gb_re;
   logic [DW-1:0] gb_din;

   // Arbiter side drives address, data and strobes, and receives read data.
   modport master (
      output gb_addr,
      output gb_dout,
      output gb_we,
      output gb_re,
      input  gb_din
   );

   // Decoded bus tree side.
   modport slave (
      input  gb_addr,
      input  gb_dout,
      input  gb_we,
      input  gb_re,
      output gb_din
   );
endinterface

// File: rtl/ghostbus_arb_grant.sv
// ghostbus_arb_grant: combinational grant select between the two host requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; build option GHOSTBUS_ARB_RR_EN switches ties from fixed priority to round-robin.
module ghostbus_arb_grant (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_idx
);

   // Pick a winner: a lone requester always wins; a tie goes to requester 0,
   // or to whichever requester was not granted last when round-robin is built in.
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_idx   = 1'b0;
      if (req0 && req1) begin
`ifdef GHOSTBUS_ARB_RR_EN
         gnt_idx = ~last_grant;
`else
         gnt_idx = 1'b0;
`endif
      end else if (req1) begin
         gnt_idx = 1'b1;
      end
   end

`ifndef GHOSTBUS_ARB_RR_EN
   // Fixed priority ignores history; keep the input visibly consumed.
   logic last_grant_unused;
   assign last_grant_unused = last_grant;
`endif

endmodule

// File: rtl/ghostbus_host_arb.sv
// ghostbus_host_arb: two-requester arbiter and sequencer for the single ghostbus host port.
// Latency: ack 2 cycles after the IDLE cycle that sees req for writes, RD_LAT+2 for reads.
// Backpressure: requesters hold req until their ack; losers and late arrivals stall, never dropped.
// Build option GHOSTBUS_ARB_RR_EN: round-robin tie-break instead of requester 0 always winning.
module ghostbus_host_arb
   import ghostbus_host_arb_pkg::*;
#(
   parameter int AW     = 24,
   parameter int DW     = 32,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                req0,
   input  logic                we0,
   input  logic [AW-1:0]       addr0,
   input  logic [DW-1:0]       wdata0,
   output logic                ack0,
   output logic [DW-1:0]       rdata0,

   input  logic                req1,
   input  logic                we1,
   input  logic [AW-1:0]       addr1,
   input  logic [DW-1:0]       wdata1,
   output logic                ack1,
   output logic [DW-1:0]       rdata1,

   ghostbus_host_arb_if.master gb,

   output logic                busy
);

   state_t             state;
   state_t             state_nxt;

   logic               gnt_valid;
   logic               gnt_idx;
   logic               last_grant;

   // Transaction latched at grant time; address and data stay on the bus
   // until the next grant so the decoded tree sees stable values.
   logic               cur_idx;
   logic               cur_we;
   logic [AW-1:0]      addr_q;
   logic [DW-1:0]      dout_q;
   logic [CNT_W-1:0]   cnt;

   logic               grant_now;
   logic               capture_now;

   assign grant_now   = (state == IDLE) && gnt_valid;
   assign capture_now = (state == WAIT) && (cnt == '0);

   ghostbus_arb_grant u_grant (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: one issue cycle, a read waits out the bus latency, one ack cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = cur_we ? ACK : WAIT;
         WAIT:    if (cnt == '0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state: strobes only in ISSUE, ack only in ACK.
   always_comb begin
      gb.gb_we = 1'b0;
      gb.gb_re = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      busy     = (state != IDLE);
      case (state)
         ISSUE: begin
            gb.gb_we = cur_we;
            gb.gb_re = ~cur_we;
         end
         ACK: begin
            ack0 = ~cur_idx;
            ack1 = cur_idx;
         end
         default: ;
      endcase
   end

   assign gb.gb_addr = addr_q;
   assign gb.gb_dout = dout_q;

   // Grant-time latch of the winner's request, grant history, and the read-latency counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_idx    <= 1'b0;
         cur_we     <= 1'b0;
         addr_q     <= '0;
         dout_q     <= '0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         if (grant_now) begin
            cur_idx    <= gnt_idx;
            last_grant <= gnt_idx;
            cur_we     <= gnt_idx ? we1    : we0;
            addr_q     <= gnt_idx ? addr1  : addr0;
            dout_q     <= gnt_idx ? wdata1 : wdata0;
         end
         if ((state == ISSUE) && !cur_we) begin
            cnt <= lat_load(RD_LAT);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Read data return: only the granted requester's register is updated.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (capture_now) begin
         if (cur_idx) begin
            rdata1 <= gb.gb_din;
         end else begin
            rdata0 <= gb.gb_din;
         end
      end
   end

endmodule
